// File: rtl/uart_rx_pkg.sv
// Shared types and frame constants for the UART receiver frame controller.
package uart_rx_pkg;

  localparam int unsigned LAST_DATA_BIT = 8;
  localparam int unsigned PRESC_MIN     = 8;
  localparam int unsigned PRESC_MAX     = 32;

  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    START  = 6'b000010,
    DATA   = 6'b000100,
    PARITY = 6'b001000,
    STOP   = 6'b010000,
    CHECK  = 6'b100000
  } state_t;

endpackage

// File: rtl/uart_rx_data_sampler.sv
// Three-tap majority sampler around the middle of each bit period.
module uart_rx_data_sampler #(
  parameter int unsigned PRESC_W = 6,
  parameter int unsigned EDGE_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [EDGE_W-1:0]  edge_count,
  output logic               sampled_bit
);

  logic [EDGE_W-1:0] mid;
  logic [1:0]        taps;

  assign mid = EDGE_W'(prescale >> 1);

  // The vote is registered on the third tap, so sampled_bit settles at mid+2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps        <= '0;
      sampled_bit <= 1'b0;
    end else begin
      if (edge_count == mid - EDGE_W'(1)) taps[0] <= rx_in;
      if (edge_count == mid)              taps[1] <= rx_in;
      if (edge_count == mid + EDGE_W'(1))
        sampled_bit <= (taps[0] & taps[1]) | (taps[0] & rx_in) | (taps[1] & rx_in);
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver frame controller: start/data/parity/stop sequencing and frame checking.
// Optional break detection is built when UART_RX_BREAK_DETECT_EN is defined.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESC_W    = 6,
  parameter int unsigned EDGE_W     = 5,
  parameter int unsigned BIT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [PRESC_W-1:0]    prescale,
  input  logic [EDGE_W-1:0]     edge_count,
  input  logic [BIT_W-1:0]      bit_count,
  input  logic                  done_edge,
  output logic                  counter_enable,
  output logic                  counter_par_en,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy,
  output logic                  break_det
);

  state_t                state, next;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_en_q, par_typ_q;
  logic                  par_flag, stp_flag;
  logic                  sampled_bit;
  logic                  chk_first, brk_c, brk_hold, brk_wait_c;

  uart_rx_data_sampler #(
    .PRESC_W (PRESC_W),
    .EDGE_W  (EDGE_W)
  ) u_sampler (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .edge_count  (edge_count),
    .sampled_bit (sampled_bit)
  );

  // First CHECK cycle is the only one that reports; later cycles just wait out a break.
  assign chk_first  = (state == CHECK) && !brk_hold;
  assign brk_wait_c = brk_c || brk_hold;

`ifdef UART_RX_BREAK_DETECT_EN
  logic par_bit;

  assign brk_c = chk_first && stp_flag && (shift == '0) && (!par_en_q || !par_bit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bit  <= 1'b0;
      brk_hold <= 1'b0;
    end else begin
      if (state == PARITY && done_edge) par_bit <= sampled_bit;
      brk_hold <= (state == CHECK) && brk_wait_c && !rx_in;
    end
  end
`else
  assign brk_c    = 1'b0;
  assign brk_hold = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:   if (!rx_in) next = START;
      START:  if (done_edge) next = sampled_bit ? IDLE : DATA;
      DATA:   if (done_edge && bit_count == BIT_W'(LAST_DATA_BIT))
                next = par_en_q ? PARITY : STOP;
      PARITY: if (done_edge) next = STOP;
      STOP:   if (done_edge) next = CHECK;
      CHECK:  if (brk_wait_c) next = rx_in ? IDLE : CHECK;
              else            next = rx_in ? IDLE : START;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    counter_enable = 1'b0;
    busy           = 1'b0;
    counter_enable = state inside {START, DATA, PARITY, STOP};
    busy           = (state != IDLE);
  end

  assign counter_par_en = par_en_q;

  // Datapath: frame-config latch, deserialiser, error flags and result pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      shift      <= '0;
      par_flag   <= 1'b0;
      stp_flag   <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      break_det  <= 1'b0;
      if (next == START && state != START) begin
        par_en_q  <= par_en;
        par_typ_q <= par_typ;
      end
      if (done_edge && state == DATA)   shift    <= {sampled_bit, shift[DATA_WIDTH-1:1]};
      if (done_edge && state == PARITY) par_flag <= sampled_bit != (^shift ^ par_typ_q);
      if (done_edge && state == STOP)   stp_flag <= ~sampled_bit;
      if (chk_first) begin
        if (!par_flag && !stp_flag) begin
          p_data     <= shift;
          data_valid <= 1'b1;
        end else begin
          par_err <= par_flag;
          stp_err <= stp_flag && !brk_c;
        end
        break_det <= brk_c;
        par_flag  <= 1'b0;
        stp_flag  <= 1'b0;
      end
    end
  end

  prescale_legal: assert property (@(posedge clk) disable iff (rst)
    (state != IDLE) |-> (prescale >= PRESC_W'(PRESC_MIN) && prescale <= PRESC_W'(PRESC_MAX)));

endmodule
